// File: rtl/seq_counter_flags_pkg.sv
// Shared sizing defaults and the request-flag vector type for the sequencing block.
// Combinational definitions only; nothing here carries state or flow control.
package seq_pkg;

  localparam int CNT_WIDTH_DEF = 4;
  localparam int N_FLAG_DEF    = 5;

  typedef logic [N_FLAG_DEF-1:0] flag_vec_t;

endpackage

// File: rtl/seq_counter_flags_if.sv
// Control/status bundle between the decode logic (master) and the sequencing block (slave).
// Registered outputs update one edge after their inputs; no backpressure, inputs are sampled every edge.
interface seq_counter_flags_if #(
  parameter int WIDTH  = seq_pkg::CNT_WIDTH_DEF,
  parameter int N_FLAG = seq_pkg::N_FLAG_DEF
);

  logic              cnt_clear;
  logic              cnt_write;
  logic              cnt_tick;
  logic              cnt_countdown;
  logic [WIDTH-1:0]  cnt_in;
  logic [WIDTH-1:0]  cnt_out;
  logic [N_FLAG-1:0] flag_set;
  logic [N_FLAG-1:0] flag_rst;
  logic [N_FLAG-1:0] flag_out;
  logic              en_set;
  logic              en_rst;
  logic              en_out;
  logic [N_FLAG-1:0] flag_masked;
  logic              pending;

  modport master (
    output cnt_clear, cnt_write, cnt_tick, cnt_countdown, cnt_in,
    output flag_set, flag_rst, en_set, en_rst,
    input  cnt_out, flag_out, en_out, flag_masked, pending
  );

  modport slave (
    input  cnt_clear, cnt_write, cnt_tick, cnt_countdown, cnt_in,
    input  flag_set, flag_rst, en_set, en_rst,
    output cnt_out, flag_out, en_out, flag_masked, pending
  );

endinterface

// File: rtl/seq_counter_flags_sr_flag.sv
// Single clocked set/reset bit; clear dominates set, rst forces RST_VAL.
// One-edge latency; no backpressure.
module sr_flag #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clr,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (clr) begin
      q <= 1'b0;
    end else if (set) begin
      q <= 1'b1;
    end
  end

endmodule

// File: rtl/seq_counter_flags.sv
// Micro-cycle up/down counter plus request flags and a global enable for interrupt decode.
// Registered state has one-edge latency, masked/pending are combinational; no backpressure.
module seq_counter_flags
  import seq_pkg::*;
#(
  parameter int WIDTH      = CNT_WIDTH_DEF,
  parameter int N_FLAG     = N_FLAG_DEF,
  parameter bit EN_RST_VAL = 1'b1
) (
  input logic              clk,
  input logic              rst,
  seq_counter_flags_if.slave bus
);

  logic [WIDTH-1:0]  cnt_q;
  logic [WIDTH-1:0]  cnt_d;
  logic [N_FLAG-1:0] flag_q;
  logic              en_q;

  // Priority clear > write > tick; arithmetic wraps modulo 2^WIDTH.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.cnt_clear) begin
      cnt_d = '0;
    end else if (bus.cnt_write) begin
      cnt_d = bus.cnt_in;
    end else if (bus.cnt_tick) begin
      cnt_d = bus.cnt_countdown ? cnt_q - WIDTH'(1) : cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  for (genvar i = 0; i < N_FLAG; i++) begin : g_flag
    sr_flag #(
      .RST_VAL(1'b0)
    ) u_flag (
      .clk (clk),
      .rst (rst),
      .set (bus.flag_set[i]),
      .clr (bus.flag_rst[i]),
      .q   (flag_q[i])
    );
  end

  sr_flag #(
    .RST_VAL(EN_RST_VAL)
  ) u_en (
    .clk (clk),
    .rst (rst),
    .set (bus.en_set),
    .clr (bus.en_rst),
    .q   (en_q)
  );

  assign bus.cnt_out     = cnt_q;
  assign bus.flag_out    = flag_q;
  assign bus.en_out      = en_q;
  assign bus.flag_masked = flag_q & {N_FLAG{en_q}};
  assign bus.pending     = |(flag_q & {N_FLAG{en_q}});

endmodule

// File: tb/tb_seq_counter_flags.sv
// Directed bench for seq_counter_flags: counter priority/wrap, flag set/reset, enable masking, reset.
module tb_seq_counter_flags;

  localparam int WIDTH  = 4;
  localparam int N_FLAG = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  seq_counter_flags_if #(.WIDTH(WIDTH), .N_FLAG(N_FLAG)) bus ();

  seq_counter_flags #(
    .WIDTH(WIDTH),
    .N_FLAG(N_FLAG),
    .EN_RST_VAL(1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it before checking.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.cnt_clear = 0; bus.cnt_write = 0; bus.cnt_tick = 0; bus.cnt_countdown = 0;
    bus.cnt_in = '0; bus.flag_set = '0; bus.flag_rst = '0; bus.en_set = 0; bus.en_rst = 0;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] c, input logic [4:0] f,
                         input logic e, input logic [4:0] m, input logic p);
    chk({tag, ".cnt"}, 32'(bus.cnt_out), 32'(c));
    chk({tag, ".flag"}, 32'(bus.flag_out), 32'(f));
    chk({tag, ".en"}, 32'(bus.en_out), 32'(e));
    chk({tag, ".masked"}, 32'(bus.flag_masked), 32'(m));
    chk({tag, ".pending"}, 32'(bus.pending), 32'(p));
  endtask

  initial begin
    idle();
    #1;
    // Reset with random activity on every input.
    rst = 1;
    bus.cnt_write = 1; bus.cnt_in = 4'($urandom); bus.cnt_tick = 1;
    bus.flag_set = 5'($urandom); bus.en_rst = 1;
    step();
    step();
    chk_all("reset", 4'd0, 5'h00, 1'b1, 5'h00, 1'b0);
    rst = 0;
    idle();

    // Count up 16 times: 1..15 then wrap to 0.
    bus.cnt_tick = 1;
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("up%0d", i), 32'(bus.cnt_out), 32'((i + 1) % 16));
    end
    bus.cnt_countdown = 1;
    step(); chk("down_wrap", 32'(bus.cnt_out), 32'd15);
    step(); chk("down_14", 32'(bus.cnt_out), 32'd14);
    idle();

    // Priority: clear beats write beats tick.
    bus.cnt_write = 1; bus.cnt_in = 4'd5;
    step(); chk("load5", 32'(bus.cnt_out), 32'd5);
    bus.cnt_clear = 1; bus.cnt_in = 4'd9; bus.cnt_tick = 1;
    step(); chk("prio_clear", 32'(bus.cnt_out), 32'd0);
    bus.cnt_clear = 0;
    step(); chk("prio_write", 32'(bus.cnt_out), 32'd9);
    bus.cnt_write = 0;
    step(); chk("prio_tick", 32'(bus.cnt_out), 32'd10);
    bus.cnt_tick = 0; bus.cnt_countdown = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("hold%0d", i), 32'(bus.cnt_out), 32'd10);
    end
    idle();

    // Request flags.
    bus.flag_set = 5'b00100;
    step(); chk_all("set2", 4'd10, 5'b00100, 1'b1, 5'b00100, 1'b1);
    bus.flag_set = '0;
    step(); chk("hold2", 32'(bus.flag_out), 32'h04);
    bus.flag_set = 5'b00100; bus.flag_rst = 5'b00100;
    step(); chk_all("set_rst2", 4'd10, 5'b00000, 1'b1, 5'b00000, 1'b0);
    bus.flag_rst = '0;
    step(); chk("reassert", 32'(bus.flag_out), 32'h04);
    bus.flag_rst = 5'b00100;
    step(); chk("held_set_cleared", 32'(bus.flag_out), 32'h00);
    bus.flag_rst = '0;
    step(); chk("held_set_back", 32'(bus.flag_out), 32'h04);
    bus.flag_set = '0; bus.flag_rst = 5'b11111;
    step(); chk("clear_all", 32'(bus.flag_out), 32'h00);
    idle();

    // Enable masking.
    bus.flag_set = 5'b10001;
    step(); chk_all("set10001", 4'd10, 5'b10001, 1'b1, 5'b10001, 1'b1);
    bus.flag_set = '0; bus.en_rst = 1;
    step(); chk_all("en_off", 4'd10, 5'b10001, 1'b0, 5'b00000, 1'b0);
    bus.en_rst = 0; bus.flag_set = 5'b00010;
    step(); chk_all("set_while_off", 4'd10, 5'b10011, 1'b0, 5'b00000, 1'b0);
    bus.flag_set = '0; bus.flag_rst = 5'b00010;
    step(); chk("clr1", 32'(bus.flag_out), 32'h11);
    bus.flag_rst = '0; bus.en_set = 1;
    step(); chk_all("en_on", 4'd10, 5'b10001, 1'b1, 5'b10001, 1'b1);
    bus.en_rst = 1;
    step(); chk_all("en_both", 4'd10, 5'b10001, 1'b0, 5'b00000, 1'b0);
    idle();

    // Reset mid-operation overrides simultaneous load and sets.
    bus.cnt_write = 1; bus.cnt_in = 4'd7; bus.en_set = 1;
    step(); chk_all("pre_rst", 4'd7, 5'b10001, 1'b1, 5'b10001, 1'b1);
    rst = 1; bus.cnt_in = 4'd3; bus.flag_set = 5'b11111; bus.en_set = 0; bus.en_rst = 1;
    step(); chk_all("mid_rst", 4'd0, 5'b00000, 1'b1, 5'b00000, 1'b0);
    rst = 0; idle();
    step(); chk_all("post_rst", 4'd0, 5'b00000, 1'b1, 5'b00000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_counter_flags.md
Name: seq_counter_flags

Overview:
- Synchronous sequencing block for the control unit.
- Contains a WIDTH-bit loadable up/down counter, used as the micro-cycle counter.
- Contains a bank of N_FLAG set/reset flags (interrupt request latches) plus one global enable flag.
- Presents the raw flags, the enable-masked flags and a pending indicator to the instruction/interrupt decode logic.

Parameters:
WIDTH, 4, counter width in bits (1..16)
N_FLAG, 5, number of request flags (1..16)
EN_RST_VAL, 1, value of the enable flag after reset

Ports:
clk  input  1  single clock; all state changes on rising edge
rst  input  1  synchronous reset, active-high
cnt_clear  input  1  synchronous clear of counter to 0
cnt_write  input  1  load counter from cnt_in
cnt_tick  input  1  count enable
cnt_countdown  input  1  1 = decrement, 0 = increment
cnt_in  input  WIDTH  load value
cnt_out  output  WIDTH  counter value (registered)
flag_set  input  N_FLAG  per-flag set request
flag_rst  input  N_FLAG  per-flag clear request
flag_out  output  N_FLAG  raw flag state (registered)
en_set  input  1  set global enable
en_rst  input  1  clear global enable
en_out  output  1  global enable state (registered)
flag_masked  output  N_FLAG  flag_out AND replicated en_out (combinational)
pending  output  1  OR-reduction of flag_masked (combinational)

Behaviour:
- One clock domain. No latches and no combinational loops; flags are clocked set/reset flip-flops.
- Reset (rst=1 at a rising edge): cnt_out=0, flag_out=0, en_out=EN_RST_VAL. rst overrides every other input in that cycle.
- Counter priority per edge, highest first:
  - rst: counter becomes 0.
  - cnt_clear: counter becomes 0.
  - cnt_write: counter becomes cnt_in.
  - cnt_tick: counter becomes cnt_out ±1.
  - Otherwise: counter holds.
- Counter arithmetic is modulo 2^WIDTH:
  - Up from all-ones wraps to 0.
  - Down from 0 wraps to all-ones.
  - No carry or borrow output.
- cnt_countdown is ignored unless a tick takes effect.
- Latency: all registered outputs reflect an edge's inputs immediately after that edge (1-cycle latency). No output changes between edges.
- Each flag i, per edge:
  - flag_rst[i]=1: flag becomes 0 (reset-dominant; wins over a simultaneous set).
  - Else flag_set[i]=1: flag becomes 1.
  - Else: flag holds.
- Enable flag: en_rst wins over en_set; otherwise the same rule as the request flags.
- Set inputs are level-sensitive. A set held high for several cycles keeps the flag at 1. A flag cleared while its set is still high re-asserts on the next edge after flag_rst drops.
- flag_masked and pending follow flag_out/en_out combinationally in the same cycle:
  - With en_out=0, flag_masked=0 and pending=0, but flag_out still records requests.
- Flags and counter are independent: any combination of inputs may be active in the same cycle.

Decomposition:
- Shared package seq_pkg holds default widths (CNT_WIDTH_DEF=4, N_FLAG_DEF=5) and a typedef for the flag vector.
- One natural sub-module: sr_flag (single reset-dominant clocked set/reset bit with parameterised reset value), instantiated N_FLAG+1 times.
- Counter logic stays inline.

Test Plan:
- Reset: drive random inputs, pulse rst for 1 cycle -> next cycle cnt_out=0, flag_out=0, en_out=1, pending=0.
- Count/wrap (WIDTH=4): tick up 16 cycles from 0 -> values 1..15 then 0. Count down from 0 -> 15, 14.
- Priority: cnt_out=5, cnt_clear=1, cnt_write=1, cnt_in=9, tick=1 in one cycle -> 0. Drop clear -> 9. Write=0, tick=1 -> 10. Tick=0 for 3 cycles -> holds 10.
- Flags: set bit2 -> flag_out=00100, pending=1. Same-cycle set2+rst2 -> 00000. Set held while rst pulsed -> flag returns to 1 the next cycle.
- Masking: flags 10001, en_rst=1 -> en_out=0, flag_masked=00000, pending=0, flag_out still 10001. en_set -> flag_masked=10001. en_set+en_rst together -> en_out=0.
- Reset mid-operation: counter=7 and flags set, rst plus cnt_write and flag_set the same cycle -> all reset values; inputs ignored that cycle.
